// File: rtl/ramp_pwm_array.sv
// ramp_pwm_array: multi-channel ramped PWM generator.
// One shared prescaler + R-bit PWM counter + step timer drive CH lanes.
// Each lane holds an (R+1)-bit duty that steps in sawtooth, triangle or hold
// mode on every step event, and registers its own compare output.
// Optional build macro RAMP_PWM_GAMMA_EN: compare against (duty*duty)>>R
// instead of duty for a perceptually linear LED fade.

module ramp_pwm_lane #(
  parameter int R    = 8,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         upd,
  input  logic [1:0]   mode,
  input  logic [R-1:0] q,
  output logic [R:0]   duty,
  output logic         pwm
);
  localparam logic [R:0] FULL   = (R+1)'(1) << R;
  localparam logic [R:0] INIT_V = (R+1)'(INIT);

  logic       up;
  logic [R:0] cmp;

`ifdef RAMP_PWM_GAMMA_EN
  // Squared duty scaled back to R+1 bits; FULL*FULL>>R is FULL, so full
  // duty still compares high against every q.
  logic [2*R+1:0] sq;
  logic           unused_sq;
  assign sq        = duty * duty;
  assign cmp       = sq[2*R:R];
  assign unused_sq = ^{sq[2*R+1], sq[R-1:0]};
`else
  assign cmp = duty;
`endif

  // Duty/direction update, all lanes together on the shared step event.
  // Wrap and turnaround use explicit endpoint compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= INIT_V;
      up   <= 1'b1;
    end else if (upd) begin
      case (mode)
        2'b00: begin
          up   <= 1'b1;
          duty <= (duty == FULL) ? '0 : duty + 1'b1;
        end
        2'b01: begin
          if (up) begin
            if (duty == FULL) begin
              // entered from sawtooth sitting at the top: turn around
              duty <= FULL - 1'b1;
              up   <= 1'b0;
            end else begin
              duty <= duty + 1'b1;
              if (duty == FULL - 1'b1) up <= 1'b0;
            end
          end else begin
            if (duty == '0) begin
              duty <= (R+1)'(1);
              up   <= 1'b1;
            end else begin
              duty <= duty - 1'b1;
              if (duty == (R+1)'(1)) up <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered compare; forced low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= en & (cmp > {1'b0, q});
  end
endmodule

module ramp_pwm_array #(
  parameter int CH           = 4,
  parameter int R            = 8,
  parameter int STEP_PERIODS = 64,
  parameter int STAGGER      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [31:0]           dvsr,
  input  logic [1:0]            mode,
  output logic [CH-1:0]         pwm_out,
  output logic [CH*(R+1)-1:0]   duty_out,
  output logic                  step
);
  localparam int SW    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SW-1:0] SP_LAST = SW'(STEP_PERIODS - 1);
  localparam int SLICE = (1 << R) / CH;

  logic [31:0]          pre;
  logic [31:0]          last;
  logic [R-1:0]         q;
  logic [SW-1:0]        scnt;
  logic                 tick;
  logic                 pwrap;
  logic                 step_evt;
  logic [CH-1:0][R:0]   duty_a;

  // dvsr of 0 behaves as 1. A >= compare lets a shrunken dvsr wrap at once.
  assign last     = (dvsr == 32'd0) ? 32'd0 : dvsr - 32'd1;
  assign tick     = en && (pre >= last);
  assign pwrap    = tick && (q == '1);
  assign step_evt = pwrap && (scnt == SP_LAST);

  // Shared timebase: prescaler, PWM counter, step timer; all clear when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      q    <= '0;
      scnt <= '0;
    end else if (!en) begin
      pre  <= '0;
      q    <= '0;
      scnt <= '0;
    end else begin
      pre <= tick ? 32'd0 : pre + 32'd1;
      if (tick)  q    <= q + 1'b1;
      if (pwrap) scnt <= step_evt ? '0 : scnt + 1'b1;
    end
  end

  // Step pulse lines up with the cycle in which the new duties appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step <= 1'b0;
    else        step <= step_evt;
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    ramp_pwm_lane #(
      .R    (R),
      .INIT ((STAGGER != 0) ? k * SLICE : 0)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .upd  (step_evt),
      .mode (mode),
      .q    (q),
      .duty (duty_a[k]),
      .pwm  (pwm_out[k])
    );
  end

  assign duty_out = duty_a;
endmodule
